// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver with mid-bit sampling.
//
// Parameter:
//   CLKS_PER_BIT  clock cycles per bit period (4 .. 16383)
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   RxD        asynchronous serial input, idle high
//   rx_ack     consumer acknowledge, clears rx_valid (and overrun)
//   data       last accepted byte, stable while rx_valid=1
//   rx_valid   byte available, held until acknowledged
//   frame_err  sticky, last frame had a low stop bit
//   overrun    sticky, a frame completed while rx_valid was still set
//   busy       receiver is not in IDLE
// Configuration:
//   UART_RX_OVERRUN_EN  defined: an unacknowledged byte is kept and the new
//                       byte is dropped with overrun raised.
//                       undefined: the new byte overwrites data, overrun is 0.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);

  logic        sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        deliver;
  logic        rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 14'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    deliver = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Output handshake: an ack in the delivery cycle frees the slot, so the
  // new byte is always accepted and no overrun is raised.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (deliver) begin
      if (valid_q && !rx_ack) begin
`ifdef UART_RX_OVERRUN_EN
        ovr_d  = 1'b1;
`else
        data_d = shift_q;
`endif
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
`ifndef UART_RX_OVERRUN_EN
    ovr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= RxD;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a frame-level
// reference model of the receiver's delivery/ack/error rules.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       rx_ack;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ferr;
  logic       exp_ovr;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .RxD      (RxD),
    .rx_ack   (rx_ack),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk8({tag, "_data"}, data, exp_data);
    chk1({tag, "_valid"}, rx_valid, exp_valid);
    chk1({tag, "_ferr"}, frame_err, exp_ferr);
    chk1({tag, "_ovr"}, overrun, exp_ovr);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Frame completion: byte b with stop level stop, ack asserted in that cycle.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack);
    if (stop) begin
      exp_ferr = 1'b0;
      if (exp_valid && !ack) begin
`ifdef UART_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_data = b;
`endif
      end else begin
        exp_data  = b;
        exp_valid = 1'b1;
        exp_ovr   = 1'b0;
      end
    end else begin
      exp_ferr = 1'b1;
      if (ack && exp_valid) begin
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
      end
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
    chk1("ack_valid", rx_valid, exp_valid);
    chk1("ack_ovr", overrun, exp_ovr);
  endtask

  // Drives one 10-bit frame starting #1 after a rising edge. Cycle c (1-based)
  // is the c-th rising edge after the falling start edge; the stop sample is
  // visible after edge 155 = 2 sync + 8 half-bit + 144 + 1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at,
                            input int ack_at, input int idle_after);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 1; c <= 10 * CPB; c++) begin
      RxD    = bits[4'((c - 1) / CPB)];
      rst    = (c == rst_at);
      rx_ack = (c == ack_at);
      tick(1);
      if (rst_at != 0) begin
        if (c == rst_at) begin
          model_reset();
          chk_all("rst_mid");
          chk1("rst_mid_busy", busy, 1'b0);
        end
      end else begin
        if (c == 100) begin
          exp_ferr = 1'b0;
          chk1("mid_busy", busy, 1'b1);
          chk1("mid_ferr", frame_err, exp_ferr);
        end
        if (c == 154) chk1("pre_valid", rx_valid, exp_valid);
        if (c == 155) begin
          model_frame(b, stop, ack_at == 155);
          chk_all("frame");
        end
      end
    end
    rst    = 1'b0;
    rx_ack = 1'b0;
    if (idle_after > 0) begin
      RxD = 1'b1;
      tick(idle_after);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         ra;

    rst    = 1'b1;
    RxD    = 1'b1;
    rx_ack = 1'b0;
    model_reset();
    exp_data = 8'hxx;
    tick(3);
    exp_data = 8'h00;
    chk_all("reset");
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(2);

    // Ack with nothing pending has no effect
    do_ack();

    // Basic frame, then ack
    send_frame(8'hA5, 1'b1, 0, 0, 4);
    chk8("a5_data", data, 8'hA5);
    do_ack();

    // Start-bit glitch shorter than half a bit
    RxD = 1'b0;
    tick(4);
    chk1("glitch_busy", busy, 1'b1);
    RxD = 1'b1;
    tick(20);
    chk1("glitch_idle", busy, 1'b0);
    chk_all("glitch");

    // Framing error, line held low, then recovery
    send_frame(8'h3C, 1'b0, 0, 0, 0);
    RxD = 1'b0;
    tick(30);
    chk1("brk_ferr", frame_err, 1'b1);
    chk1("brk_valid", rx_valid, 1'b0);
    chk1("brk_busy", busy, 1'b1);
    RxD = 1'b1;
    tick(10);
    chk1("brk_idle", busy, 1'b0);
    send_frame(8'h55, 1'b1, 0, 0, 4);
    chk8("r55_data", data, 8'h55);
    chk1("r55_ferr", frame_err, 1'b0);
    do_ack();

    // Two frames without ack
    send_frame(8'h11, 1'b1, 0, 0, 4);
    send_frame(8'h22, 1'b1, 0, 0, 4);
`ifdef UART_RX_OVERRUN_EN
    chk8("ovr_data", data, 8'h11);
    chk1("ovr_flag", overrun, 1'b1);
`else
    chk8("ovr_data", data, 8'h22);
    chk1("ovr_flag", overrun, 1'b0);
`endif
    chk1("ovr_valid", rx_valid, 1'b1);
    do_ack();

    // Reset in the 4th data bit of 0xFF
    send_frame(8'hFF, 1'b1, 4 * CPB + 6, 0, 8);
    chk_all("post_rst");
    chk1("post_rst_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b1, 0, 0, 4);
    chk8("r7e_data", data, 8'h7E);
    do_ack();

    // Ack coinciding with delivery, prior byte pending
    send_frame(8'h42, 1'b1, 0, 0, 4);
    send_frame(8'h99, 1'b1, 0, 155, 4);
    chk8("same_data", data, 8'h99);
    chk1("same_valid", rx_valid, 1'b1);
    chk1("same_ovr", overrun, 1'b0);
    do_ack();

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0) ? 155 : 0;
      if ($urandom_range(0, 1) == 1) do_ack();
      send_frame(rb, rs, 0, ra, 4);
    end
    chk_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
